div_int_iter: RTL

DIV_INT_ITER -- requirements
Module: div_int_iter

---
 rtl/div_int_iter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/div_int_iter.sv
// Iterative restoring radix-2 integer divider (unsigned / two's-complement signed).
// Define DIV_INT_ITER_EARLY_OUT_EN to bypass iteration for trivial requests.
module div_int_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             opcode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             a_neg_c;
  logic             b_neg_c;
  logic             div_zero_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             fits_c;
  logic [WIDTH-1:0] rem_nx_c;
  logic             early_c;
  logic [WIDTH-1:0] early_q_c;
  logic [WIDTH-1:0] early_r_c;

  // Operand magnitudes and one restoring step; acc_q shifts dividend bits out and quotient bits in
  always_comb begin
    a_neg_c    = opcode & dividend[WIDTH-1];
    b_neg_c    = opcode & divisor[WIDTH-1];
    a_mag_c    = a_neg_c ? -dividend : dividend;
    b_mag_c    = b_neg_c ? -divisor : divisor;
    div_zero_c = (divisor == '0);
    rem_sh_c   = {rem_q, acc_q[WIDTH-1]};
    fits_c     = rem_sh_c[WIDTH] | (rem_sh_c[WIDTH-1:0] >= dsr_q);
    rem_nx_c   = fits_c ? (rem_sh_c[WIDTH-1:0] - dsr_q) : rem_sh_c[WIDTH-1:0];
  end

`ifdef DIV_INT_ITER_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_c;

  always_comb begin
    ovf_c     = opcode & (dividend == MIN_NEG) & (divisor == '1);
    early_c   = div_zero_c | ovf_c | (a_mag_c < b_mag_c);
    early_q_c = div_zero_c ? '1 : (ovf_c ? MIN_NEG : '0);
    early_r_c = ovf_c ? '0 : dividend;
  end
`else
  always_comb begin
    early_c   = 1'b0;
    early_q_c = '0;
    early_r_c = '0;
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready_out <= 1'b0;
      valid_out <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      acc_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (valid_in && ready_out) begin
            ready_out <= 1'b0;
            // Divide-by-zero keeps the all-ones magnitude quotient unsigned
            q_neg_q   <= (a_neg_c ^ b_neg_c) & ~div_zero_c;
            r_neg_q   <= a_neg_c;
            if (early_c) begin
              state     <= DONE;
              valid_out <= 1'b1;
              quotient  <= early_q_c;
              remainder <= early_r_c;
            end else begin
              state <= CALC;
              acc_q <= a_mag_c;
              dsr_q <= b_mag_c;
              rem_q <= '0;
              cnt_q <= CNT_LOAD;
            end
          end
        end
        CALC: begin
          // The cycle that finds the counter at zero hands over to FIX
          if (cnt_q != '0) begin
            acc_q <= {acc_q[WIDTH-2:0], fits_c};
            rem_q <= rem_nx_c;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= q_neg_q ? -acc_q : acc_q;
          remainder <= r_neg_q ? -rem_q : rem_q;
          valid_out <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
